// File: rtl/connect4_drop_engine_pkg.sv
// Shared encodings for the Connect-4 drop engine: FSM states, move status codes
// and player identifiers.
package connect4_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLACE  = 2'd1,
    S_RESP   = 2'd2,
    S_LOCKED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK          = 2'b00,
    ST_BAD_COL     = 2'b01,
    ST_COL_FULL    = 2'b10,
    ST_OUT_OF_TURN = 2'b11
  } status_e;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

endpackage

// File: rtl/connect4_drop_engine_if.sv
// Move request/response bus between the game controller (master) and the
// drop engine (slave), including the board state it publishes.
interface connect4_drop_engine_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int COL_W = 3,
  parameter int ROW_W = 2
) ();
  localparam int CELLS = ROWS * COLS;

  logic             new_game;
  logic             move_valid;
  logic             move_ready;
  logic             move_player;
  logic [COL_W-1:0] move_col;
  logic             move_done;
  logic [1:0]       move_status;
  logic [ROW_W-1:0] landed_row;
  logic [CELLS-1:0] board_occ;
  logic [CELLS-1:0] board_owner;
  logic             cur_player;
  logic             board_full;

  modport master (
    output new_game, move_valid, move_player, move_col,
    input  move_ready, move_done, move_status, landed_row,
           board_occ, board_owner, cur_player, board_full
  );

  modport slave (
    input  new_game, move_valid, move_player, move_col,
    output move_ready, move_done, move_status, landed_row,
           board_occ, board_owner, cur_player, board_full
  );
endinterface

// File: rtl/connect4_drop_engine_col_heights.sv
// Per-column fill counters; reports the height and full flag of the selected
// column. Out-of-range columns read as height 0, not full.
module connect4_col_heights #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int COL_W = 3,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [COL_W-1:0] col_i,
  output logic [ROW_W:0]   height_o,
  output logic             full_o
);
  localparam logic [ROW_W:0] H_ONE = 1;

  logic [ROW_W:0] h_q [COLS];

  always_comb begin
    height_o = '0;
    for (int c = 0; c < COLS; c++)
      if (int'(col_i) == c) height_o = h_q[c];
  end

  assign full_o = (int'(col_i) < COLS) && (int'(height_o) == ROWS);

  // Saturate at ROWS so a stray inc can never wrap a full column.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int c = 0; c < COLS; c++) h_q[c] <= '0;
    end else if (inc_i) begin
      for (int c = 0; c < COLS; c++)
        if (int'(col_i) == c && int'(h_q[c]) < ROWS) h_q[c] <= h_q[c] + H_ONE;
    end
  end
endmodule

// File: rtl/connect4_drop_engine.sv
// Connect-4 board owner: accepts one move per handshake, applies gravity,
// rejects illegal moves and locks once every cell is filled.
module connect4_drop_engine
  import connect4_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int COL_W = 3,
  parameter int ROW_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  connect4_drop_engine_if.slave  bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int CNT_W = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic             player_q, player_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CELLS-1:0] occ_q, occ_d;
  logic [CELLS-1:0] own_q, own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cur_q, cur_d;
  logic             done_q, done_d;
  logic             full_q, full_d;
  status_e          status_q, status_d;
  logic [ROW_W-1:0] landed_q, landed_d;

  logic [ROW_W:0]   height;
  logic             col_full;
  logic             inc;

  connect4_col_heights #(
    .ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W)
  ) u_heights (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (bus.new_game),
    .inc_i    (inc),
    .col_i    (col_q),
    .height_o (height),
    .full_o   (col_full)
  );

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    col_d    = col_q;
    occ_d    = occ_q;
    own_d    = own_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    done_d   = 1'b0;
    full_d   = full_q;
    status_d = status_q;
    landed_d = landed_q;
    inc      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.move_valid) begin
          player_d = bus.move_player;
          col_d    = bus.move_col;
          state_d  = S_PLACE;
        end
      end
      S_PLACE: begin
        done_d  = 1'b1;
        state_d = S_RESP;
        // Check order matters: a bad column wins over a wrong player.
        if (int'(col_q) >= COLS)        status_d = ST_BAD_COL;
        else if (player_q != cur_q)     status_d = ST_OUT_OF_TURN;
        else if (col_full)              status_d = ST_COL_FULL;
        else begin
          for (int i = 0; i < CELLS; i++)
            if (i == int'(height) * COLS + int'(col_q)) begin
              occ_d[i] = 1'b1;
              own_d[i] = player_q;
            end
          landed_d = height[ROW_W-1:0];
          inc      = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
          cur_d    = ~cur_q;
          status_d = ST_OK;
        end
      end
      S_RESP: begin
        if (int'(cnt_q) == CELLS) begin
          state_d = S_LOCKED;
          full_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      state_q  <= S_IDLE;
      player_q <= PLAYER1;
      col_q    <= '0;
      occ_q    <= '0;
      own_q    <= '0;
      cnt_q    <= '0;
      cur_q    <= PLAYER1;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      status_q <= ST_OK;
      landed_q <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      col_q    <= col_d;
      occ_q    <= occ_d;
      own_q    <= own_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      done_q   <= done_d;
      full_q   <= full_d;
      status_q <= status_d;
      landed_q <= landed_d;
    end
  end

  assign bus.move_ready  = (state_q == S_IDLE);
  assign bus.move_done   = done_q;
  assign bus.move_status = status_q;
  assign bus.landed_row  = landed_q;
  assign bus.board_occ   = occ_q;
  assign bus.board_owner = own_q;
  assign bus.cur_player  = cur_q;
  assign bus.board_full  = full_q;
endmodule

// File: tb/tb_connect4_drop_engine.sv
// Bench for the drop engine: directed vector table, full-board / abort
// sequences, and random moves against a 2-D board reference model.
module tb_connect4_drop_engine;
  localparam int ROWS = 4, COLS = 4, COL_W = 3, ROW_W = 2;
  localparam int CELLS = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  connect4_drop_engine_if #(.ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  connect4_drop_engine #(.ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: brd[col][row] = -1 empty, else owning player
  int brd [COLS][ROWS];
  int hgt [COLS];
  int m_cur, m_cnt;
  bit m_full;

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) begin
      hgt[c] = 0;
      for (int r = 0; r < ROWS; r++) brd[c][r] = -1;
    end
    m_cur = 0; m_cnt = 0; m_full = 0;
  endtask

  task automatic model_move(input int p, input int c, output int st, output int row);
    row = 0;
    if (c >= COLS)           st = 1;
    else if (p != m_cur)     st = 3;
    else if (hgt[c] == ROWS) st = 2;
    else begin
      brd[c][hgt[c]] = p;
      row = hgt[c];
      hgt[c]++;
      m_cnt++;
      m_cur = 1 - m_cur;
      st = 0;
      if (m_cnt == CELLS) m_full = 1;
    end
  endtask

  function automatic logic [31:0] m_occ();
    logic [31:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (brd[c][r] >= 0) v[r*COLS + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] m_own();
    logic [31:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (brd[c][r] == 1) v[r*COLS + c] = 1'b1;
    return v;
  endfunction

  task automatic check_board(input string tag);
    chk({tag, "_occ"},   32'(bus.board_occ),   m_occ());
    chk({tag, "_owner"}, 32'(bus.board_owner), m_own());
    chk({tag, "_cur"},   32'(bus.cur_player),  32'(m_cur));
    chk({tag, "_full"},  32'(bus.board_full),  32'(m_full));
  endtask

  // Called at a negedge; returns at the negedge after move_done has dropped.
  task automatic do_move(input logic p, input logic [COL_W-1:0] c,
                         output logic [1:0] st, output logic [ROW_W-1:0] row);
    int n = 0;
    while (!bus.move_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.move_ready) begin
      chk("ready_wait", 32'(bus.move_ready), 32'd1);
      st = 2'bxx; row = 'x;
      return;
    end
    bus.move_valid = 1'b1; bus.move_player = p; bus.move_col = c;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    @(negedge clk);
    chk("done_in_place",  32'(bus.move_done),  32'd0);
    chk("ready_in_place", 32'(bus.move_ready), 32'd0);
    @(negedge clk);
    chk("done_in_resp", 32'(bus.move_done), 32'd1);
    st = bus.move_status; row = bus.landed_row;
    @(negedge clk);
    chk("done_after", 32'(bus.move_done), 32'd0);
  endtask

  task automatic pulse_new_game();
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic             pl;
    logic [COL_W-1:0] col;
    logic [1:0]       st;
    logic [ROW_W-1:0] row;
  } vec_t;
  vec_t vecs [10];

  initial begin
    logic [1:0] st;
    logic [ROW_W-1:0] row;
    int est, erow;
    logic p;
    logic [COL_W-1:0] c;

    vecs[0] = '{1'b0, 3'd2, 2'b00, 2'd0};
    vecs[1] = '{1'b1, 3'd2, 2'b00, 2'd1};
    vecs[2] = '{1'b0, 3'd5, 2'b01, 2'd0};
    vecs[3] = '{1'b1, 3'd0, 2'b11, 2'd0};
    vecs[4] = '{1'b1, 3'd7, 2'b01, 2'd0};
    vecs[5] = '{1'b0, 3'd0, 2'b00, 2'd0};
    vecs[6] = '{1'b1, 3'd0, 2'b00, 2'd1};
    vecs[7] = '{1'b0, 3'd0, 2'b00, 2'd2};
    vecs[8] = '{1'b1, 3'd0, 2'b00, 2'd3};
    vecs[9] = '{1'b0, 3'd0, 2'b10, 2'd0};

    bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_player = 1'b0; bus.move_col = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    chk("rst_occ",   32'(bus.board_occ),   32'd0);
    chk("rst_owner", 32'(bus.board_owner), 32'd0);
    chk("rst_cur",   32'(bus.cur_player),  32'd0);
    chk("rst_ready", 32'(bus.move_ready),  32'd1);
    chk("rst_full",  32'(bus.board_full),  32'd0);
    chk("rst_done",  32'(bus.move_done),   32'd0);

    for (int i = 0; i < 10; i++) begin
      do_move(vecs[i].pl, vecs[i].col, st, row);
      model_move(int'(vecs[i].pl), int'(vecs[i].col), est, erow);
      chk($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].st));
      if (vecs[i].st == 2'b00) chk($sformatf("vec%0d_row", i), 32'(row), 32'(vecs[i].row));
      check_board($sformatf("vec%0d", i));
    end
    chk("table_occ",   32'(bus.board_occ),   32'h1155);
    chk("table_owner", 32'(bus.board_owner), 32'h1050);

    // Fill the whole board, then confirm the lock holds against a pending request.
    pulse_new_game();
    for (int i = 0; i < CELLS; i++) begin
      do_move(1'(i % 2), COL_W'(i % COLS), st, row);
      chk("fill_status", 32'(st), 32'd0);
    end
    chk("fill_full",  32'(bus.board_full), 32'd1);
    chk("fill_occ",   32'(bus.board_occ),  32'hFFFF);
    bus.move_valid = 1'b1; bus.move_player = 1'b0; bus.move_col = 3'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("locked_ready", 32'(bus.move_ready), 32'd0);
      chk("locked_done",  32'(bus.move_done),  32'd0);
    end
    bus.move_valid = 1'b0;
    pulse_new_game();
    chk("ng_occ",   32'(bus.board_occ),   32'd0);
    chk("ng_owner", 32'(bus.board_owner), 32'd0);
    chk("ng_cur",   32'(bus.cur_player),  32'd0);
    chk("ng_ready", 32'(bus.move_ready),  32'd1);
    chk("ng_full",  32'(bus.board_full),  32'd0);
    chk("ng_stat",  32'(bus.move_status), 32'd0);
    chk("ng_row",   32'(bus.landed_row),  32'd0);

    // Abort a legal move with new_game during its PLACE cycle.
    bus.move_valid = 1'b1; bus.move_player = 1'b0; bus.move_col = 3'd1;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_done", 32'(bus.move_done), 32'd0);
      @(negedge clk);
    end
    chk("abort_occ", 32'(bus.board_occ), 32'd0);
    do_move(1'b0, 3'd1, st, row);
    chk("abort_next_status", 32'(st),  32'd0);
    chk("abort_next_row",    32'(row), 32'd0);
    chk("abort_next_occ",    32'(bus.board_occ), 32'h0002);

    // Random play against the model; mostly in-turn, columns sometimes illegal.
    pulse_new_game();
    for (int i = 0; i < 300; i++) begin
      if (m_full) begin
        chk("rnd_locked_ready", 32'(bus.move_ready), 32'd0);
        pulse_new_game();
      end
      p = ($urandom_range(0, 3) == 0) ? 1'(1 - m_cur) : 1'(m_cur);
      c = COL_W'($urandom_range(0, 6));
      do_move(p, c, st, row);
      model_move(int'(p), int'(c), est, erow);
      chk("rnd_status", 32'(st), 32'(est));
      if (est == 0) chk("rnd_row", 32'(row), 32'(erow));
      check_board("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
